// File: rtl/hazard_scan_if.sv
// -----------------------------------------------------------------------------
// hazard_scan_if
//
// Bundles the decode/writeback handshake and the shared-comparator signals
// of hazard_scan_ctrl.
//
//   master : the environment (decode, writeback, external comparator)
//   slave  : the scoreboard / scan controller
//
// Signals
//   alloc_valid/alloc_rd/alloc_ready : record a pending destination register
//   retire_valid                     : pop the oldest pending entry
//   chk_valid/chk_rs/chk_ready       : hazard check request
//   hit_valid/hit                    : one-cycle check result
//   count                            : number of pending entries
//   cmp_a/cmp_b/cmp_y                : shared equality comparator operands/result
// -----------------------------------------------------------------------------
interface hazard_scan_if #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             alloc_valid;
    logic [WIDTH-1:0] alloc_rd;
    logic             alloc_ready;
    logic             retire_valid;
    logic             chk_valid;
    logic [WIDTH-1:0] chk_rs;
    logic             chk_ready;
    logic             hit_valid;
    logic             hit;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] cmp_a;
    logic [WIDTH-1:0] cmp_b;
    logic             cmp_y;

    modport master (
        output alloc_valid, alloc_rd, retire_valid, chk_valid, chk_rs, cmp_y,
        input  alloc_ready, chk_ready, hit_valid, hit, count, cmp_a, cmp_b
    );

    modport slave (
        input  alloc_valid, alloc_rd, retire_valid, chk_valid, chk_rs, cmp_y,
        output alloc_ready, chk_ready, hit_valid, hit, count, cmp_a, cmp_b
    );
endinterface

// File: rtl/hazard_scan_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_scan_ctrl
//
// In-order scoreboard of in-flight destination registers plus a scan
// controller that walks the pending entries (oldest first, one per cycle)
// through a single shared external equality comparator to decide whether a
// source register is still pending.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : hazard_scan_if.slave (alloc, retire, check, result, count,
//          comparator operands cmp_a/cmp_b and comparator result cmp_y)
//
// Parameters
//   WIDTH : register address width
//   DEPTH : scoreboard entries (power of two, >= 2)
//
// Optional feature
//   HAZARD_X0_FILTER_EN : when defined, a check of register 0 completes
//   immediately with hit=0 without using the comparator. When undefined,
//   register 0 is scanned like any other address.
//
// Result latency (check accepted at edge T): empty -> T+1, hit on entry k
// -> T+k+2, miss over N entries -> T+N+1.
// -----------------------------------------------------------------------------
module hazard_scan_ctrl #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    hazard_scan_if.slave bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SCAN = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
    localparam logic [PW-1:0]    PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]    PTR_ONE  = PW'(1);
    localparam logic [WIDTH-1:0] REG_ZERO = {WIDTH{1'b0}};

    // Storage and pointers
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    // Control and scan context
    logic [1:0]       state_r;
    logic [WIDTH-1:0] rs_r;
    logic [PW-1:0]    snap_ptr_r;
    logic [CW-1:0]    snap_cnt_r;
    logic [CW-1:0]    idx_r;

    // Registered outputs
    logic             hit_r;
    logic             hit_valid_r;
    logic [WIDTH-1:0] cmp_a_r;
    logic [WIDTH-1:0] cmp_b_r;

    // Next-state values
    logic [1:0]       state_n_s;
    logic [WIDTH-1:0] rs_n_s;
    logic [PW-1:0]    snap_ptr_n_s;
    logic [CW-1:0]    snap_cnt_n_s;
    logic [CW-1:0]    idx_n_s;
    logic             hit_n_s;
    logic             hit_valid_n_s;
    logic [WIDTH-1:0] cmp_a_n_s;
    logic [WIDTH-1:0] cmp_b_n_s;

    // Handshake decode
    logic             alloc_ready_s;
    logic             alloc_fire_s;
    logic             retire_fire_s;
    logic             chk_fire_s;
    logic             x0_skip_s;
    logic             idx_last_s;
    logic [PW-1:0]    scan_addr_s;

    assign alloc_ready_s = (count_r != CNT_FULL) && (state_r == ST_IDLE);
    assign alloc_fire_s  = bus.alloc_valid && alloc_ready_s;
    assign retire_fire_s = bus.retire_valid && (count_r != CNT_ZERO);
    assign chk_fire_s    = bus.chk_valid && (state_r == ST_IDLE);

`ifdef HAZARD_X0_FILTER_EN
    // Register 0 never carries a hazard, so it bypasses the scan.
    assign x0_skip_s = (bus.chk_rs == REG_ZERO);
`else
    assign x0_skip_s = 1'b0;
`endif

    // Entry compared in the next SCAN cycle; wraps naturally in PW bits.
    // Alloc is blocked outside IDLE, so the snapshot region stays intact.
    assign scan_addr_s = snap_ptr_r + idx_r[PW-1:0] + PTR_ONE;
    assign idx_last_s  = (idx_r == (snap_cnt_r - CNT_ONE));

    // Scan FSM next-state and next registered-output logic.
    always_comb begin
        state_n_s     = state_r;
        rs_n_s        = rs_r;
        snap_ptr_n_s  = snap_ptr_r;
        snap_cnt_n_s  = snap_cnt_r;
        idx_n_s       = idx_r;
        hit_n_s       = hit_r;
        hit_valid_n_s = 1'b0;
        cmp_a_n_s     = REG_ZERO;
        cmp_b_n_s     = REG_ZERO;
        case (state_r)
            ST_IDLE: begin
                if (chk_fire_s) begin
                    // Snapshot uses pre-event rd_ptr/count: a same-cycle
                    // alloc lands outside the snapshot window.
                    rs_n_s       = bus.chk_rs;
                    snap_ptr_n_s = rd_ptr_r;
                    snap_cnt_n_s = count_r;
                    idx_n_s      = CNT_ZERO;
                    if ((count_r == CNT_ZERO) || x0_skip_s) begin
                        state_n_s     = ST_DONE;
                        hit_n_s       = 1'b0;
                        hit_valid_n_s = 1'b1;
                    end else begin
                        state_n_s = ST_SCAN;
                        cmp_a_n_s = bus.chk_rs;
                        cmp_b_n_s = mem_r[rd_ptr_r];
                    end
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (bus.cmp_y) begin
                    state_n_s     = ST_DONE;
                    hit_n_s       = 1'b1;
                    hit_valid_n_s = 1'b1;
                end else if (idx_last_s) begin
                    state_n_s     = ST_DONE;
                    hit_n_s       = 1'b0;
                    hit_valid_n_s = 1'b1;
                end else begin
                    idx_n_s   = idx_r + CNT_ONE;
                    cmp_a_n_s = rs_r;
                    cmp_b_n_s = mem_r[scan_addr_s];
                end
            end
            ST_DONE: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Control state, pointers, occupancy, scan context and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            wr_ptr_r    <= PTR_ZERO;
            rd_ptr_r    <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            rs_r        <= REG_ZERO;
            snap_ptr_r  <= PTR_ZERO;
            snap_cnt_r  <= CNT_ZERO;
            idx_r       <= CNT_ZERO;
            hit_r       <= 1'b0;
            hit_valid_r <= 1'b0;
            cmp_a_r     <= REG_ZERO;
            cmp_b_r     <= REG_ZERO;
        end else begin
            state_r     <= state_n_s;
            rs_r        <= rs_n_s;
            snap_ptr_r  <= snap_ptr_n_s;
            snap_cnt_r  <= snap_cnt_n_s;
            idx_r       <= idx_n_s;
            hit_r       <= hit_n_s;
            hit_valid_r <= hit_valid_n_s;
            cmp_a_r     <= cmp_a_n_s;
            cmp_b_r     <= cmp_b_n_s;
            if (alloc_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (retire_fire_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            // Alloc and retire together leave the occupancy unchanged.
            case ({alloc_fire_s, retire_fire_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (alloc_fire_s && !rst) begin
            mem_r[wr_ptr_r] <= bus.alloc_rd;
        end
    end

    assign bus.alloc_ready = alloc_ready_s;
    assign bus.chk_ready   = (state_r == ST_IDLE);
    assign bus.hit_valid   = hit_valid_r;
    assign bus.hit         = hit_r;
    assign bus.count       = count_r;
    assign bus.cmp_a       = cmp_a_r;
    assign bus.cmp_b       = cmp_b_r;

endmodule

// File: tb/tb_hazard_scan_ctrl.sv
module tb_hazard_scan_ctrl;
    localparam int WIDTH = 5;
    localparam int DEPTH = 4;

`ifdef HAZARD_X0_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_scan_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    hazard_scan_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // external equality comparator
    assign bus.cmp_y = (bus.cmp_a == bus.cmp_b);

    typedef struct {
        bit hit;
        int cyc;
    } exp_t;

    exp_t sb[$];      // expected results, in order
    int   pend[$];    // pending destination registers, oldest first
    int   snap[$];    // copy of pend taken when the last check was accepted
    int   cyc      = 0;
    int   busy_end = -1;   // cycle in which the outstanding result is shown
    int   acc_c    = -1;   // cycle in which the last check was accepted
    int   scan_rs  = 0;
    int   n_cmp    = 0;
    int   n_fail   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: oldest-first search of the pending list.
    function automatic void predict(input int rs, output bit h, output int lat);
        bit found;
        found = 1'b0;
        h     = 1'b0;
        lat   = pend.size() + 1;
        if (pend.size() == 0 || (FILT && rs == 0)) begin
            lat = 1;
        end else begin
            for (int k = 0; k < pend.size(); k++) begin
                if (!found && pend[k] == rs) begin
                    found = 1'b1;
                    h     = 1'b1;
                    lat   = k + 2;
                end
            end
        end
    endfunction

    // One cycle: drive at negedge, check outputs, update the model, advance.
    task automatic step(input bit av, input int ard, input bit rv, input bit cv, input int crs);
        bit idle, aok, h;
        int lat, n0;
        bus.alloc_valid  = av;
        bus.alloc_rd     = ard[WIDTH-1:0];
        bus.retire_valid = rv;
        bus.chk_valid    = cv;
        bus.chk_rs       = crs[WIDTH-1:0];
        #1;
        idle = (cyc > busy_end);
        n0   = pend.size();
        aok  = idle && (n0 < DEPTH);
        chk("count", 32'(bus.count), n0);
        chk("alloc_ready", 32'(bus.alloc_ready), int'(aok));
        chk("chk_ready", 32'(bus.chk_ready), int'(idle));
        if (cyc > acc_c && cyc < busy_end) begin
            chk("cmp_a_scan", 32'(bus.cmp_a), scan_rs);
            chk("cmp_b_scan", 32'(bus.cmp_b), snap[cyc - acc_c - 1]);
        end else begin
            chk("cmp_a_quiet", 32'(bus.cmp_a), 0);
            chk("cmp_b_quiet", 32'(bus.cmp_b), 0);
        end
        if (cv && idle) begin
            predict(crs, h, lat);
            sb.push_back('{h, cyc + lat});
            acc_c    = cyc;
            busy_end = cyc + lat;
            scan_rs  = crs;
            snap     = pend;
        end
        if (rv && n0 != 0) void'(pend.pop_front());
        if (av && aok) pend.push_back(ard);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2 * DEPTH + 4 && cyc <= busy_end; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
    endtask

    // Assert reset asynchronously, check reset values, release on next negedge.
    task automatic pulse_reset();
        bus.alloc_valid  = 1'b0;
        bus.retire_valid = 1'b0;
        bus.chk_valid    = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_hit_valid", 32'(bus.hit_valid), 0);
        chk("rst_hit", 32'(bus.hit), 0);
        chk("rst_cmp_a", 32'(bus.cmp_a), 0);
        chk("rst_cmp_b", 32'(bus.cmp_b), 0);
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_alloc_ready", 32'(bus.alloc_ready), 1);
        chk("rst_chk_ready", 32'(bus.chk_ready), 1);
        pend.delete();
        sb.delete();
        snap.delete();
        busy_end = -1;
        acc_c    = -1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a result is shown or is overdue.
    exp_t e;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.hit_valid || (sb.size() != 0 && cyc >= sb[0].cyc)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_hit_valid", 32'(bus.hit_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk("hit_valid_present", 32'(bus.hit_valid), 1);
                    chk("hit_valid_cycle", 32'(cyc), e.cyc);
                    if (bus.hit_valid) chk("hit_value", 32'(bus.hit), int'(e.hit));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.alloc_valid  = 1'b0;
        bus.alloc_rd     = '0;
        bus.retire_valid = 1'b0;
        bus.chk_valid    = 1'b0;
        bus.chk_rs       = '0;
        @(negedge clk);
        pulse_reset();

        // empty check
        step(0, 0, 0, 1, 21);
        wait_idle();

        // hit on entry 1, miss over 3 entries
        step(1, 3, 0, 0, 0);
        step(1, 21, 0, 0, 0);
        step(1, 17, 0, 0, 0);
        step(0, 0, 0, 1, 21);
        wait_idle();
        step(0, 0, 0, 1, 9);
        wait_idle();

        // full, alloc while full, retire, alloc+retire together
        step(1, 8, 0, 0, 0);
        step(1, 30, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 12, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // wrap: retire 2, alloc 2, check newest
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 25, 0, 0, 0);
        step(1, 6, 0, 0, 0);
        step(0, 0, 0, 1, 6);
        wait_idle();

        // drain and retire on empty
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // retire during scan: result follows the snapshot
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 7, 0, 0, 0);
        step(0, 0, 1, 1, 7);
        step(0, 0, 1, 0, 0);
        wait_idle();

        // reset in the middle of a scan
        step(1, 4, 0, 0, 0);
        step(1, 5, 0, 0, 0);
        step(0, 0, 0, 1, 5);
        step(0, 0, 0, 0, 0);
        pulse_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);

        // register 0
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        wait_idle();
        step(0, 0, 1, 0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 7)));
        end

        wait_idle();
        step(0, 0, 0, 0, 0);
        chk("scoreboard_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_scan_ctrl.md
# hazard_scan_ctrl

In-order scoreboard and scan controller for the multicycle core's register-hazard check. It records destination register addresses of in-flight instructions in a small circular buffer. On request, it sequences a single shared external `comparator` (equality, WIDTH bits) over the pending entries, one entry per cycle, to decide whether a source register is still pending. It sits between decode (check requests, allocation) and writeback (retire).

## Interface

**Parameters**
- `WIDTH`, default 5: register address width.
- `DEPTH`, default 4: scoreboard entries; power of two, ≥2.

**Ports**
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `alloc_valid`  in  1: record a new pending destination.
- `alloc_rd`  in  WIDTH: destination register to record.
- `alloc_ready`  out  1: allocation accepted this cycle when high together with `alloc_valid`.
- `retire_valid`  in  1: pop the oldest entry.
- `chk_valid`  in  1: hazard check request.
- `chk_rs`  in  WIDTH: source register to check.
- `chk_ready`  out  1: check accepted when high together with `chk_valid`.
- `hit_valid`  out  1: one-cycle result strobe.
- `hit`  out  1: 1 = `chk_rs` matches a pending entry; valid only while `hit_valid` is high.
- `count`  out  $clog2(DEPTH+1): number of pending entries.
- `cmp_a`  out  WIDTH: operand a of the shared comparator.
- `cmp_b`  out  WIDTH: operand b of the shared comparator.
- `cmp_y`  in  1: comparator equality output, combinational in the same cycle.

## Operation

**Storage**
- Circular buffer of DEPTH entries, with `wr_ptr`, `rd_ptr` and `count`.
- Pointers wrap modulo DEPTH.

**Alloc**
- Condition: `alloc_valid && alloc_ready`.
- Writes `alloc_rd` at `wr_ptr`, then `wr_ptr+1` and `count+1`.
- `alloc_ready = (count != DEPTH) && state==IDLE`.

**Retire**
- Condition: `retire_valid && count != 0`. Performs `rd_ptr+1` and `count-1`.
- Accepted in any state.
- Retire when empty is ignored.

**Simultaneous events**
- Alloc and retire in the same cycle: both take effect, `count` unchanged.

**FSM**
- **IDLE**
  - `chk_ready=1`.
  - On check accept: latch `chk_rs` and snapshot `rd_ptr` and `count` (the value before any same-cycle alloc or retire). Clear the scan index.
  - If the snapshot count is 0, go to DONE with `hit=0`; otherwise go to SCAN.
- **SCAN**
  - Drive `cmp_a` = latched rs and `cmp_b` = entry[snap_ptr+idx].
  - If `cmp_y`=1: go to DONE with `hit=1`.
  - Else if idx == snap_count-1: go to DONE with `hit=0`.
  - Else idx+1.
- **DONE**
  - `hit_valid=1` for exactly one cycle, `hit` held; then go to IDLE.

**Behaviour during SCAN/DONE**
- `chk_ready=0` and `alloc_ready=0`.
- Retire still moves `rd_ptr`/`count`. Because alloc is blocked, the snapshotted entries are unchanged, so the scan completes against the snapshot. This is conservative: a stale hit is allowed, a missed hazard is not.
- `cmp_a`/`cmp_b` = 0 outside SCAN.

**Reset (asserted)**
- Immediately: state=IDLE, pointers and `count` = 0, `hit_valid=0`, `hit=0`, `cmp_a=cmp_b=0`, `alloc_ready=1`, `chk_ready=1`.
- Entry contents are don't-care.
- Reset mid-scan aborts the scan; no `hit_valid` is produced.

## Timing

Check accepted at edge T:
- Empty scoreboard: `hit_valid` in cycle T+1.
- Hit on entry k (0 = oldest): `hit_valid` in cycle T+k+2.
- Miss with N entries: `hit_valid` in cycle T+N+1.
- Worst case: DEPTH+1 cycles.

Next check accepted no earlier than the cycle after `hit_valid`.

## Configuration

Macro `HAZARD_X0_FILTER_EN`:
- **Defined:** `chk_rs == 0` goes IDLE→DONE with `hit=0` (`hit_valid` at T+1) regardless of `count`. The comparator is not driven.
- **Undefined:** register 0 is scanned like any other address.

## Test plan

- Reset, then `count`=0. Check rs=5'b10101 → `hit_valid` at T+1, `hit`=0, `cmp_a`/`cmp_b` stay 0.
- Alloc 3, 21, 17. Check rs=21 → `hit`=1 at T+3. Check rs=9 → `hit`=0 at T+4.
- Fill 4 entries → `alloc_ready`=0. Alloc while full is ignored (`count` stays 4). Retire once → `count`=3, `alloc_ready`=1. Alloc+retire in the same cycle → `count` stays 3.
- Wrap: retire 2 and alloc 2 past index 3. Check the newest rd → hit at the correct offset (oldest-relative). Retire on empty → `count` stays 0.
- Retire during SCAN → scan finishes on the snapshot and still reports the hit. `rst` pulsed mid-SCAN → no `hit_valid`, all outputs at reset values.
- With `HAZARD_X0_FILTER_EN`: alloc rd=0, check rs=0 → `hit`=0 at T+1. Without the macro: same stimulus → `hit`=1 at T+2.
